// File: rtl/adc_scan_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_seq_if
// Description : Signal bundle between the ADC scan sequencer and its user /
//               ADC front end.
//               master : drives en, trig, ADC_5000, rd_addr
//               slave  : drives st, mux_sel, rd_data, valid, busy, scan_done
// Revision    : 1.0  initial release
// ============================================================================
interface adc_scan_seq_if;
    logic        en;         // continuous scan enable
    logic        trig;       // single-scan request
    logic [11:0] ADC_5000;   // conversion result from the ADC
    logic        st;         // conversion start pulse
    logic [1:0]  mux_sel;    // analog mux channel select
    logic [1:0]  rd_addr;    // result channel to read
    logic [11:0] rd_data;    // averaged result of channel rd_addr
    logic [3:0]  valid;      // per-channel "has a result" flags
    logic        busy;       // sequencer not idle
    logic        scan_done;  // end-of-scan pulse

    modport master (
        output en, trig, ADC_5000, rd_addr,
        input  st, mux_sel, rd_data, valid, busy, scan_done
    );

    modport slave (
        input  en, trig, ADC_5000, rd_addr,
        output st, mux_sel, rd_data, valid, busy, scan_done
    );
endinterface
`default_nettype wire

// File: rtl/adc_scan_seq.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_seq
// Description : Four-channel ADC scan sequencer. For each channel it selects
//               the mux, waits SETTLE cycles, then takes 2^AVG_LOG2
//               conversions (st pulse, CONV_CYC wait, latch) and stores the
//               truncated average. Single scan on trig, continuous scans
//               separated by GAP idle cycles while en is high.
// Ports       : clk, rst  - clock, synchronous active-high reset
//               bus        - adc_scan_seq_if.slave (en, trig, ADC_5000,
//                            rd_addr in; st, mux_sel, rd_data, valid, busy,
//                            scan_done out)
// Revision    : 1.0  initial release
// ============================================================================
module adc_scan_seq #(
    parameter int SETTLE   = 16,
    parameter int CONV_CYC = 64,
    parameter int AVG_LOG2 = 2,
    parameter int GAP      = 1000
) (
    input  wire logic      clk,
    input  wire logic      rst,
    adc_scan_seq_if.slave  bus
);

    // One shared cycle counter serves SETTLE, CONV and GAP_WAIT.
    localparam int c_max_a   = (SETTLE > CONV_CYC) ? SETTLE : CONV_CYC;
    localparam int c_max_cnt = (c_max_a > GAP) ? c_max_a : GAP;
    localparam int c_cnt_w   = $clog2(c_max_cnt + 1);
    localparam int c_acc_w   = 12 + AVG_LOG2;
    localparam int c_samp_w  = AVG_LOG2 + 1;

    localparam logic [c_cnt_w-1:0]  c_settle_last = c_cnt_w'(SETTLE - 1);
    localparam logic [c_cnt_w-1:0]  c_conv_last   = c_cnt_w'(CONV_CYC - 1);
    localparam logic [c_cnt_w-1:0]  c_gap_last    = c_cnt_w'(GAP - 1);
    localparam logic [c_samp_w-1:0] c_samp_last   = c_samp_w'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETTLE   = 3'd1,
        S_START    = 3'd2,
        S_CONV     = 3'd3,
        S_LATCH    = 3'd4,
        S_GAP_WAIT = 3'd5
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_samp_w-1:0]  r_samp;
    logic [c_acc_w-1:0]   r_acc;
    logic [1:0]           r_mux;
    logic                 r_st;
    logic                 r_busy;
    logic                 r_done;
    logic [3:0]           r_valid;
    logic [11:0]          r_result [0:3];

    logic [c_acc_w-1:0]   w_sum;
    logic [11:0]          w_avg;

    // The accumulator is wide enough for 2^AVG_LOG2 full-scale samples,
    // so the sum never wraps.
    assign w_sum = r_acc + c_acc_w'(bus.ADC_5000);
    assign w_avg = 12'(w_sum >> AVG_LOG2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_samp  <= '0;
            r_acc   <= '0;
            r_mux   <= 2'd0;
            r_st    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                r_result[i] <= 12'd0;
            end
        end else begin
            r_st   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.en || bus.trig) begin
                        r_state <= S_SETTLE;
                        r_mux   <= 2'd0;
                        r_acc   <= '0;
                        r_samp  <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == c_settle_last) begin
                        r_state <= S_START;
                        r_st    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_START: begin
                    r_state <= S_CONV;
                    r_cnt   <= '0;
                end
                S_CONV: begin
                    if (r_cnt == c_conv_last) begin
                        r_state <= S_LATCH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_LATCH: begin
                    if (r_samp != c_samp_last) begin
                        // More samples on this channel: mux already settled.
                        r_acc   <= w_sum;
                        r_samp  <= r_samp + 1'b1;
                        r_state <= S_START;
                        r_st    <= 1'b1;
                    end else begin
                        r_result[r_mux] <= w_avg;
                        r_valid[r_mux]  <= 1'b1;
                        r_acc           <= '0;
                        r_samp          <= '0;
                        r_cnt           <= '0;
                        if (r_mux != 2'd3) begin
                            r_mux   <= r_mux + 2'd1;
                            r_state <= S_SETTLE;
                        end else begin
                            r_mux  <= 2'd0;
                            r_done <= 1'b1;
                            if (bus.en) begin
                                r_state <= S_GAP_WAIT;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                end
                S_GAP_WAIT: begin
                    if (r_cnt == c_gap_last) begin
                        r_cnt <= '0;
                        if (bus.en) begin
                            r_state <= S_SETTLE;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.st        = r_st;
    assign bus.mux_sel   = r_mux;
    assign bus.busy      = r_busy;
    assign bus.scan_done = r_done;
    assign bus.valid     = r_valid;
    assign bus.rd_data   = r_result[bus.rd_addr];

endmodule
`default_nettype wire
